rv_trace_buffer: RTL and testbench

- Synthesizable retire-trace capture buffer for the RV32I cores: records one {PC, instr, result} per retired instruction into a circular buffer, stops on a PC-match trigger plus a programmable post-trigger window, then drains oldest-first over a valid/ready port.
- Parametrised successor to the per-cycle debug print monitor, generalised in XLEN and depth, with trigger, wrap and drain behaviour.
- Sits beside the core's retire stage and is observed by the bench or a debug unit.

---
 rtl/rv_trace_buffer.sv | 185 ++++++++++++++++++
 tb/tb_rv_trace_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_trace_buffer.sv
// Retire-trace capture buffer: circular record store with PC trigger, post-trigger window and oldest-first drain.
// Optional per-record cycle timestamp enabled by defining RV_TRACE_TIMESTAMP_EN.
module rv_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
`ifdef RV_TRACE_TIMESTAMP_EN
    ,
    parameter int TS_W  = 16
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            trc_valid,
    input  logic [XLEN-1:0] trc_pc,
    input  logic [31:0]     trc_instr,
    input  logic [XLEN-1:0] trc_result,
    input  logic            arm,
    input  logic            clear,
    input  logic            trig_en,
    input  logic [XLEN-1:0] trig_pc,
    input  logic [AW:0]     post_cnt,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [XLEN-1:0] rd_pc,
    output logic [31:0]     rd_instr,
    output logic [XLEN-1:0] rd_result,
    output logic            rd_last,
`ifdef RV_TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0] rd_tstamp,
`endif
    output logic [1:0]      state,
    output logic [AW:0]     count,
    output logic            wrapped
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_MAXP = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    state_t            state_reg;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic [AW:0]       post_reg;
    logic [AW:0]       post_lat_reg;
    logic              trig_en_reg;
    logic [XLEN-1:0]   trig_pc_reg;
    logic              wrapped_reg;

    logic [XLEN-1:0]   pc_mem     [DEPTH];
    logic [31:0]       instr_mem  [DEPTH];
    logic [XLEN-1:0]   result_mem [DEPTH];

    logic              capture;
    logic              full;
    logic              rd_valid_int;
    logic              accept;
    logic [AW:0]       post_clamped;

    assign capture      = trc_valid && !clear &&
                          (state_reg == S_ARMED || state_reg == S_POST);
    assign full         = (count_reg == CNT_FULL);
    assign rd_valid_int = (state_reg == S_DONE) && (count_reg != '0);
    assign accept       = rd_valid_int && rd_ready;
    // Capping the window at DEPTH-1 keeps the trigger record resident.
    assign post_clamped = (post_cnt > CNT_MAXP) ? CNT_MAXP : post_cnt;

    // Storage has no reset so it maps onto RAM; gating hides stale contents.
    always_ff @(posedge clk) begin
        if (capture) begin
            pc_mem[wr_ptr_reg]     <= trc_pc;
            instr_mem[wr_ptr_reg]  <= trc_instr;
            result_mem[wr_ptr_reg] <= trc_result;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            post_reg     <= '0;
            post_lat_reg <= '0;
            trig_en_reg  <= 1'b0;
            trig_pc_reg  <= '0;
            wrapped_reg  <= 1'b0;
        end else if (clear) begin
            state_reg   <= S_IDLE;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            post_reg    <= '0;
            wrapped_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (arm) begin
                        trig_en_reg  <= trig_en;
                        trig_pc_reg  <= trig_pc;
                        post_lat_reg <= post_clamped;
                        wr_ptr_reg   <= '0;
                        rd_ptr_reg   <= '0;
                        count_reg    <= '0;
                        post_reg     <= '0;
                        wrapped_reg  <= 1'b0;
                        state_reg    <= S_ARMED;
                    end
                end
                S_ARMED, S_POST: begin
                    if (trc_valid) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                        if (full) begin
                            rd_ptr_reg  <= rd_ptr_reg + PTR_ONE;
                            wrapped_reg <= 1'b1;
                        end else begin
                            count_reg <= count_reg + CNT_ONE;
                        end
                        if (state_reg == S_ARMED) begin
                            if (trig_en_reg) begin
                                if (trc_pc == trig_pc_reg) begin
                                    post_reg  <= post_lat_reg;
                                    state_reg <= (post_lat_reg == '0) ? S_DONE : S_POST;
                                end
                            end else if (count_reg == CNT_MAXP) begin
                                state_reg <= S_DONE;
                            end
                        end else begin
                            post_reg <= post_reg - CNT_ONE;
                            if (post_reg == CNT_ONE)
                                state_reg <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (accept) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                        count_reg  <= count_reg - CNT_ONE;
                        if (count_reg == CNT_ONE)
                            state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

`ifdef RV_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_reg;
    logic [TS_W-1:0] ts_mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ts_reg <= '0;
        else
            ts_reg <= ts_reg + TS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (capture)
            ts_mem[wr_ptr_reg] <= ts_reg;
    end

    assign rd_tstamp = rd_valid_int ? ts_mem[rd_ptr_reg] : '0;
`endif

    assign rd_valid  = rd_valid_int;
    assign rd_last   = rd_valid_int && (count_reg == CNT_ONE);
    assign rd_pc     = rd_valid_int ? pc_mem[rd_ptr_reg]     : '0;
    assign rd_instr  = rd_valid_int ? instr_mem[rd_ptr_reg]  : '0;
    assign rd_result = rd_valid_int ? result_mem[rd_ptr_reg] : '0;
    assign state     = state_reg;
    assign count     = count_reg;
    assign wrapped   = wrapped_reg;

endmodule

// File: tb/tb_rv_trace_buffer.sv
// Bench for rv_trace_buffer: directed scenarios plus randomized runs checked against a queue-based model.
module tb_rv_trace_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            trc_valid = 1'b0;
    logic [31:0]     trc_pc = '0;
    logic [31:0]     trc_instr = '0;
    logic [31:0]     trc_result = '0;
    logic            arm = 1'b0;
    logic            clear = 1'b0;
    logic            trig_en = 1'b0;
    logic [31:0]     trig_pc = '0;
    logic [AW:0]     post_cnt = '0;
    logic            rd_valid;
    logic            rd_ready = 1'b0;
    logic [31:0]     rd_pc;
    logic [31:0]     rd_instr;
    logic [31:0]     rd_result;
    logic            rd_last;
    logic [1:0]      state;
    logic [AW:0]     count;
    logic            wrapped;

    always #5 clk = ~clk;

    rv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .trc_valid(trc_valid), .trc_pc(trc_pc), .trc_instr(trc_instr), .trc_result(trc_result),
        .arm(arm), .clear(clear), .trig_en(trig_en), .trig_pc(trig_pc), .post_cnt(post_cnt),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr),
        .rd_result(rd_result), .rd_last(rd_last),
        .state(state), .count(count), .wrapped(wrapped)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] result;
    } rec_t;

    // Model: the buffer is simply the last DEPTH captured records, oldest first.
    rec_t        q[$];
    int          m_state = 0;
    bit          m_wrapped = 0;
    bit          m_ten = 0;
    logic [31:0] m_tpc = '0;
    int          m_post = 0;
    int          m_left = 0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_state"},   32'(state),    32'(m_state));
        check({tag, "_count"},   32'(count),    32'(q.size()));
        check({tag, "_wrapped"}, 32'(wrapped),  32'(m_wrapped));
        check({tag, "_rdvalid"}, 32'(rd_valid), 32'(m_state == 3 && q.size() != 0));
    endtask

    task automatic model_clear();
        q.delete();
        m_state   = 0;
        m_wrapped = 0;
    endtask

    task automatic do_arm(input bit ten, input logic [31:0] tpc, input int post);
        arm = 1'b1; trig_en = ten; trig_pc = tpc; post_cnt = (AW+1)'(post);
        @(posedge clk);
        if (m_state == 0) begin
            q.delete();
            m_wrapped = 0;
            m_state   = 1;
            m_ten     = ten;
            m_tpc     = tpc;
            m_post    = (post > DEPTH - 1) ? DEPTH - 1 : post;
        end
        @(negedge clk);
        arm = 1'b0;
        check_status("arm");
    endtask

    task automatic model_retire(input rec_t r);
        if (m_state == 1 || m_state == 2) begin
            q.push_back(r);
            if (q.size() > DEPTH) begin
                void'(q.pop_front());
                m_wrapped = 1;
            end
            if (m_state == 1) begin
                if (m_ten) begin
                    if (r.pc == m_tpc) begin
                        m_left  = m_post;
                        m_state = (m_post == 0) ? 3 : 2;
                    end
                end else if (q.size() == DEPTH) begin
                    m_state = 3;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_state = 3;
            end
        end
    endtask

    // n retires with PCs pc0, pc0+4, ...; optional random idle cycles between them.
    task automatic run_retires(input int n, input logic [31:0] pc0, input bit gaps);
        int issued = 0;
        for (int cyc = 0; cyc < 4 * n + 20 && issued < n; cyc++) begin
            rec_t r;
            bit   v;
            v = !gaps || ($urandom_range(0, 3) != 0);
            r.pc     = pc0 + 32'(4 * issued);
            r.instr  = $urandom;
            r.result = $urandom;
            trc_valid = v; trc_pc = r.pc; trc_instr = r.instr; trc_result = r.result;
            @(posedge clk);
            if (v) begin
                model_retire(r);
                issued++;
            end
            @(negedge clk);
            trc_valid = 1'b0;
            check_status("cap");
        end
    endtask

    // mode 0: random rd_ready; mode 1: hold 5 cycles then alternate.
    task automatic drain(input int mode);
        for (int cyc = 0; cyc < 300 && m_state == 3; cyc++) begin
            bit rdy;
            if (q.size() != 0 && rd_valid === 1'b1) begin
                check("rd_pc",     rd_pc,     q[0].pc);
                check("rd_instr",  rd_instr,  q[0].instr);
                check("rd_result", rd_result, q[0].result);
                check("rd_last",   32'(rd_last), 32'(q.size() == 1));
            end
            if (mode == 0) rdy = ($urandom_range(0, 1) == 1);
            else           rdy = (cyc >= 5) && (cyc % 2 == 1);
            rd_ready = rdy;
            @(posedge clk);
            if (rdy && q.size() != 0) begin
                void'(q.pop_front());
                if (q.size() == 0) m_state = 0;
            end
            @(negedge clk);
            rd_ready = 1'b0;
            check_status("drain");
        end
        check("drain_end_state", 32'(state), 32'd0);
        check("idle_rd_pc",      rd_pc,      32'd0);
        check("idle_rd_last",    32'(rd_last), 32'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        clear = 1'b0;
        check_status("clear");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_status("reset");
        check("reset_rd_pc",   rd_pc,         32'd0);
        check("reset_rd_last", 32'(rd_last),  32'd0);
        reset = 1'b0;
        @(negedge clk);
        $display("txn reset released");

        // Fill-once: DONE after the 16th of 20 retires, no wrap.
        do_arm(1'b0, 32'h0, 0);
        run_retires(20, 32'h0, 1'b0);
        check("fill_count",   32'(count),   32'd16);
        check("fill_wrapped", 32'(wrapped), 32'd0);
        check("fill_first",   rd_pc,        32'h0);
        drain(0);
        $display("txn fill-once drained total=%0d bad=%0d", total, bad);

        // Trigger with wrap, drained under backpressure.
        do_arm(1'b1, 32'h40, 3);
        run_retires(25, 32'h0, 1'b0);
        check("wrap_state",   32'(state),   32'd3);
        check("wrap_wrapped", 32'(wrapped), 32'd1);
        check("wrap_first",   rd_pc,        32'h10);
        drain(1);
        $display("txn trigger-wrap drained total=%0d bad=%0d", total, bad);

        // post_cnt=0: trigger on the 3rd retire stops at once.
        do_arm(1'b1, 32'h8, 0);
        run_retires(6, 32'h0, 1'b0);
        check("post0_count", 32'(count), 32'd3);
        drain(0);
        $display("txn post0 drained total=%0d bad=%0d", total, bad);

        // Clamp: post_cnt=20 limits to 15 post records; trigger record drains first.
        do_arm(1'b1, 32'h4, 20);
        run_retires(32, 32'h0, 1'b0);
        check("clamp_count", 32'(count), 32'd16);
        check("clamp_first", rd_pc,      32'h4);
        drain(0);
        $display("txn clamp drained total=%0d bad=%0d", total, bad);

        // Randomized captures with idle gaps.
        for (int k = 0; k < 8; k++) begin
            bit          ten;
            logic [31:0] base;
            int          n;
            ten  = ($urandom_range(0, 3) != 0);
            base = 32'($urandom_range(0, 255)) << 2;
            n    = $urandom_range(4, 40);
            do_arm(ten, base + 32'(4 * $urandom_range(0, 30)), $urandom_range(0, 31));
            run_retires(n, base, 1'b1);
            if (m_state == 3) drain(0);
            else              do_clear();
            $display("txn random run %0d n=%0d total=%0d bad=%0d", k, n, total, bad);
        end

        // Asynchronous reset in the middle of POST.
        do_arm(1'b1, 32'h10, 10);
        run_retires(7, 32'h0, 1'b0);
        check("midpost_state", 32'(state), 32'd2);
        #2 reset = 1'b1;
        #1;
        model_clear();
        check_status("async_reset");
        @(negedge clk);
        reset = 1'b0;
        check_status("after_reset");
        $display("txn reset mid-POST total=%0d bad=%0d", total, bad);

        // Clear in DONE with five entries held.
        do_arm(1'b1, 32'h10, 0);
        run_retires(5, 32'h0, 1'b0);
        check("preclear_count", 32'(count), 32'd5);
        check("preclear_state", 32'(state), 32'd3);
        do_clear();
        $display("txn clear in DONE total=%0d bad=%0d", total, bad);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
